imem_responder: RTL
===================

Name: imem_responder

Overview:
- Instruction-memory responder: the far end of the fetch-address interface that the fetch stage drives.
- Accepts one fetch address at a time over a valid/ready request channel and models a configurable-latency instruction memory.
- Returns the instruction word, its address and an error flag over a valid/ready response channel.
- Honours a flush from branch redirect. A side write port preloads or patches program contents.

Parameters:
- WIDTH, 32, address and instruction width in bits.
- DEPTH, 256, memory size in WIDTH-bit words; power of two.
- LATENCY, 2, cycles from request acceptance to resp_valid_out; legal range 1..8.
- NOP, 32'h0000_0013, instruction returned on an error response.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- req_valid_in  input  1  fetch request valid.
- req_ready_out  output  1  responder can accept a request.
- req_addr_in  input  WIDTH  byte address of the fetch.
- flush_in  input  1  discard the in-flight request and any pending response.
- resp_valid_out  output  1  response valid.
- resp_ready_in  input  1  consumer accepts the response.
- resp_instr_out  output  WIDTH  instruction word.
- resp_addr_out  output  WIDTH  byte address the response belongs to.
- resp_err_out  output  1  misaligned or out-of-range fetch.
- wr_en_in  input  1  memory write enable.
- wr_addr_in  input  $clog2(DEPTH)  word index to write.
- wr_data_in  input  WIDTH  write data.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset (rst_in=0, async): state=IDLE, wait counter=0, resp_valid_out=0, resp_instr_out=0, resp_addr_out=0, resp_err_out=0. Memory array is not reset.
- req_ready_out (combinational) = (state==IDLE) | (state==RESP & resp_ready_in) | flush_in. It is 0 while rst_in=0.
- Acceptance = req_valid_in & req_ready_out. On acceptance:
  - Latch req_addr_in.
  - If LATENCY==1, go to RESP next edge.
  - Otherwise go to WAIT with counter=LATENCY-1.
- WAIT: counter decrements each cycle. When counter==1, the next edge enters RESP.
- Result: resp_valid_out rises exactly LATENCY cycles after the acceptance edge.
- Entering RESP, the outputs are registered:
  - resp_addr_out = latched address.
  - err = (addr[1:0]!=0) | (addr[WIDTH-1:2] >= DEPTH).
  - resp_instr_out = err ? NOP : mem[addr[$clog2(DEPTH)+1:2]].
  - resp_err_out = err.
- RESP: outputs are held stable until resp_ready_in=1.
  - On handshake with no new acceptance: IDLE, resp_valid_out=0.
  - On handshake with a same-cycle acceptance: WAIT, or RESP again if LATENCY==1. This gives back-to-back throughput of one request per LATENCY cycles.
- Flush (flush_in=1) has the highest priority over all other transitions:
  - Any WAIT request and any RESP response are discarded, and resp_valid_out=0 next cycle.
  - A request presented in the flush cycle is accepted, carrying the redirect target; otherwise the FSM goes to IDLE.
  - A response handshaking in the flush cycle is considered consumed.
- Memory:
  - Single write per cycle; the write is visible to reads from the next edge.
  - A write landing on the same edge as the RESP capture is not seen; the old data is returned.
  - wr_* is independent of the FSM and of flush.
- Reset mid-operation: the in-flight request is dropped and no response is ever produced for it.
- Only one request is outstanding at any time; there is no internal queueing.

Test Plan:
- LATENCY=2, mem[4]=32'hDEAD_BEEF, request addr 0x10 in cycle 0 with resp_ready_in=1:
  - resp_valid_out=1 in cycle 2 with instr 0xDEADBEEF, addr 0x10, err=0.
  - req_ready_out=1 again in cycle 2.
- Misaligned addr 0x12, then out-of-range addr 0x400 (DEPTH=256) -> both responses carry instr 0x00000013 and err=1.
- Backpressure: hold resp_ready_in=0 for 5 cycles in RESP:
  - Outputs stay stable and req_ready_out=0.
  - Release with a new request in the same cycle -> new response LATENCY cycles later.
- Flush in WAIT with a new request at 0x80 -> the old response never appears, and the response for 0x80 arrives LATENCY cycles after the flush. Repeat the flush in RESP with no new request -> resp_valid_out=0 next cycle, state IDLE.
- Write mem[4]=0x1234_5678 on the RESP-entry edge of a fetch to 0x10 -> the response returns old data; an immediate refetch of 0x10 returns 0x12345678.
- Assert rst_in=0 asynchronously mid-WAIT -> resp_valid_out=0 immediately; after release, no stale response appears and req_ready_out=1.

Source files
------------

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fixed-latency instruction memory responder for the fetch interface
module imem_responder #(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 256,
    parameter int               LATENCY = 2,
    parameter logic [WIDTH-1:0] NOP     = WIDTH'(32'h0000_0013)
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       req_valid_in,
    output logic                       req_ready_out,
    input  logic [WIDTH-1:0]           req_addr_in,
    input  logic                       flush_in,
    output logic                       resp_valid_out,
    input  logic                       resp_ready_in,
    output logic [WIDTH-1:0]           resp_instr_out,
    output logic [WIDTH-1:0]           resp_addr_out,
    output logic                       resp_err_out,
    input  logic                       wr_en_in,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr_in,
    input  logic [WIDTH-1:0]           wr_data_in
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [WIDTH-1:0]  addr_q;
    logic [WIDTH-1:0]  cap_addr;
    logic              capture;
    logic              accept;
    logic              cap_err;
    logic [WIDTH-1:0]  mem [DEPTH];

    // A slot frees up when idle, when the held response is being consumed,
    // or when a flush throws away whatever is in flight.
    assign req_ready_out  = rst_in & ((state == IDLE) |
                                      ((state == RESP) & resp_ready_in) |
                                      flush_in);
    assign accept         = req_valid_in & req_ready_out;
    assign resp_valid_out = (state == RESP);

    // With single-cycle latency the response is built from the address being accepted now.
    assign cap_addr = ((LATENCY == 1) && accept) ? req_addr_in : addr_q;
    assign cap_err  = (cap_addr[1:0] != 2'b00) | (cap_addr[WIDTH-1:AW+2] != '0);

    // Next-state logic; a new acceptance (only possible with flush while busy) wins over everything.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        if (accept) begin
            if (LATENCY == 1) begin
                state_n = RESP;
                capture = 1'b1;
            end else begin
                state_n = WAIT;
                cnt_n   = CW'(LATENCY - 1);
            end
        end else if (flush_in) begin
            state_n = IDLE;
        end else begin
            case (state)
                WAIT: begin
                    if (cnt == CW'(1)) begin
                        state_n = RESP;
                        capture = 1'b1;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready_in) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, latched request address and registered response fields.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            cnt            <= '0;
            addr_q         <= '0;
            resp_instr_out <= '0;
            resp_addr_out  <= '0;
            resp_err_out   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                addr_q <= req_addr_in;
            end
            if (capture) begin
                resp_addr_out  <= cap_addr;
                resp_err_out   <= cap_err;
                resp_instr_out <= cap_err ? NOP : mem[cap_addr[AW+1:2]];
            end
        end
    end

    // Program store; a write on the capture edge is not seen by that capture.
    always_ff @(posedge clk_in) begin
        if (wr_en_in) begin
            mem[wr_addr_in] <= wr_data_in;
        end
    end

endmodule
